// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the timer state encoding and the per-digit BCD limits.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    EXPIRED
  } timer_state_t;

  // Digits loaded from outside may be non-BCD (A..F); clamp them to 9.
  function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown chain: loadable, decrements on dec_en,
// wraps 0 -> 9 and reports a borrow to the next more significant digit.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_en,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  assign borrow_out = dec_en & (digit == '0);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_digit;
    end else if (dec_en) begin
      digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: load/start/pause control, ripple-borrow
// decrement on tick, one-cycle done pulse and optional periodic reload.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    auto_reload,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);

  localparam int W = BCD_W * DIGITS;

  timer_state_t  state;
  logic [W-1:0]  reload_q;
  logic [W-1:0]  load_sat;
  logic [W-1:0]  digit_val;
  logic          digit_load;
  logic          tick_act;
  logic          start_reload;
  logic          underflow;
  logic          auto_mode;
  logic          count_is_one;
  logic [DIGITS:0] chain;

  assign auto_mode    = auto_reload && (reload_q != '0);
  assign zero         = (count == '0);
  assign count_is_one = (count == W'(1));
  assign running      = (state == RUN);

  // A tick only counts when no command claims the cycle.
  assign tick_act     = !load && !pause && !start && tick && (state == RUN);
  assign start_reload = !load && !pause && start && (state == EXPIRED) && (reload_q != '0);

  // Ticking while already at zero ripples a borrow out of the top digit;
  // that is the wrap point where periodic mode reloads and one-shot clamps.
  assign chain[0]  = tick_act;
  assign underflow = chain[DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign load_sat[BCD_W*gi +: BCD_W] = sat_digit(load_val[BCD_W*gi +: BCD_W]);

    bcd_digit_down u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .dec_en     (chain[gi]),
      .load       (digit_load),
      .load_digit (digit_val[BCD_W*gi +: BCD_W]),
      .digit      (count[BCD_W*gi +: BCD_W]),
      .borrow_out (chain[gi+1])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    digit_load = 1'b0;
    digit_val  = reload_q;
    if (load) begin
      digit_load = 1'b1;
      digit_val  = load_sat;
    end else if (start_reload) begin
      digit_load = 1'b1;
    end else if (underflow) begin
      digit_load = 1'b1;
      if (!auto_mode) digit_val = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      reload_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        reload_q <= load_sat;
        state    <= IDLE;
      end else if (pause) begin
        if (state == RUN) state <= PAUSED;
      end else if (start) begin
        case (state)
          IDLE, PAUSED: if (!zero) state <= RUN;
          EXPIRED:      if (reload_q != '0) state <= RUN;
          default:      ;
        endcase
      end else if (tick && state == RUN) begin
        if (underflow) begin
          if (!auto_mode) state <= EXPIRED;
        end else if (count_is_one) begin
          done <= 1'b1;
          if (!auto_mode) state <= EXPIRED;
        end
      end
    end
  end

endmodule
